pipeline_hazard_ctrl: RTL and testbench

//  Hazard/stall/flush sequencer for the 5-stage pipeline around the ID stage (reg file, imm gen, main ctrl).

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/hz_sat_counter.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
//   state_e        : sequencer states
//   pipe_ctrl_t    : bundle of pipeline register enables/flushes
//   MEMTOREG_LOAD  : MemtoReg encoding that marks a load
//   NOP_INST       : instruction loaded into IF/ID when it is flushed
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned MEMTOREG_W = 2;

  localparam logic [MEMTOREG_W-1:0] MEMTOREG_LOAD = 2'b01;
  localparam logic [31:0]           NOP_INST      = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_ctrl_t;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   clr_i      : synchronous clear (wins over inc_i)
//   inc_i      : count up by one, holding at all-ones
//   cnt_o      : current count
module hz_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush sequencer around the ID stage of a 5-stage pipeline.
//   clk, rst (async active-low)
//   Rs1/Rs2_addr_ID, Rs1/Rs2_used_ID : ID source operands
//   Rd_addr_EX, RegWrite_EX, MemtoReg_EX : EX destination / load detection
//   Redirect_EX : taken branch or jump resolved in EX
//   Mem_req_MEM, MIO_ready : data memory handshake
//   PC_en .. MEM_WB_en, IF_ID_flush, ID_EX_flush : pipeline register controls (combinational)
//   mem_timeout : sticky, memory wait exceeded WAIT_MAX
//   stall_cnt, flush_cnt : saturating debug counters
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1_addr_ID,
  input  logic [REG_ADDR_W-1:0] Rs2_addr_ID,
  input  logic                  Rs1_used_ID,
  input  logic                  Rs2_used_ID,
  input  logic [REG_ADDR_W-1:0] Rd_addr_EX,
  input  logic                  RegWrite_EX,
  input  logic [MEMTOREG_W-1:0] MemtoReg_EX,
  input  logic                  Redirect_EX,
  input  logic                  Mem_req_MEM,
  input  logic                  MIO_ready,
  output logic                  PC_en,
  output logic                  IF_ID_en,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_en,
  output logic                  ID_EX_flush,
  output logic                  EX_MEM_en,
  output logic                  MEM_WB_en,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

  state_e            state_q, state_d;
  pipe_ctrl_t        ctrl_c;
  logic              lu_c, mw_c, resolve_c;
  logic              stall_inc_c, flush_inc_c, wait_inc_c, wait_clr_c;
  logic              timeout_q, timeout_d;
  logic [WAIT_W-1:0] wait_cnt;

  // Load-use: EX load writes a non-x0 register that the ID instruction reads.
  assign lu_c = RegWrite_EX && (MemtoReg_EX == MEMTOREG_LOAD) && (Rd_addr_EX != '0) &&
                ((Rs1_used_ID && (Rs1_addr_ID == Rd_addr_EX)) ||
                 (Rs2_used_ID && (Rs2_addr_ID == Rd_addr_EX)));

  assign mw_c = Mem_req_MEM && !MIO_ready;

  // Next state and pipeline controls.
  always_comb begin
    state_d     = state_q;
    ctrl_c      = '0;
    resolve_c   = 1'b0;
    stall_inc_c = 1'b0;
    flush_inc_c = 1'b0;
    wait_inc_c  = 1'b0;
    wait_clr_c  = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      ST_INIT: begin
        ctrl_c  = '{pc_en: 1'b0, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
                    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mw_c) begin
          // Wait count is always zero in RUN, so one increment yields 1.
          wait_inc_c = 1'b1;
          state_d    = ST_MEM_WAIT;
        end else begin
          resolve_c = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (MIO_ready) begin
          resolve_c  = 1'b1;
          wait_clr_c = 1'b1;
          state_d    = ST_RUN;
        end else begin
          wait_inc_c = 1'b1;
          if (wait_cnt == WAIT_W'(WAIT_MAX)) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Pipe is moving: redirect beats load-use (the flush kills the dependent inst anyway).
    if (resolve_c) begin
      if (Redirect_EX) begin
        ctrl_c      = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
                        id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
        flush_inc_c = 1'b1;
      end else if (lu_c) begin
        ctrl_c      = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
                        id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
        stall_inc_c = 1'b1;
      end else begin
        ctrl_c      = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
                        id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (1'b0),
    .inc_i (stall_inc_c),
    .cnt_o (stall_cnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (1'b0),
    .inc_i (flush_inc_c),
    .cnt_o (flush_cnt)
  );

  hz_sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (wait_clr_c),
    .inc_i (wait_inc_c),
    .cnt_o (wait_cnt)
  );

  assign PC_en       = ctrl_c.pc_en;
  assign IF_ID_en    = ctrl_c.if_id_en;
  assign IF_ID_flush = ctrl_c.if_id_flush;
  assign ID_EX_en    = ctrl_c.id_ex_en;
  assign ID_EX_flush = ctrl_c.id_ex_flush;
  assign EX_MEM_en   = ctrl_c.ex_mem_en;
  assign MEM_WB_en   = ctrl_c.mem_wb_en;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WAIT_MAX = 8;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  // {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_en}
  localparam logic [6:0] C_INIT   = 7'b0111111;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_REDIR  = 7'b1111111;
  localparam logic [6:0] C_STALL  = 7'b0001111;
  localparam logic [6:0] C_NORMAL = 7'b1101011;

  logic             clk, rst;
  logic [4:0]       rs1, rs2, rd;
  logic             u1, u2, rw, redir, req, rdy;
  logic [1:0]       m2r;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .Rs1_addr_ID (rs1),
    .Rs2_addr_ID (rs2),
    .Rs1_used_ID (u1),
    .Rs2_used_ID (u2),
    .Rd_addr_EX  (rd),
    .RegWrite_EX (rw),
    .MemtoReg_EX (m2r),
    .Redirect_EX (redir),
    .Mem_req_MEM (req),
    .MIO_ready   (rdy),
    .PC_en       (pc_en),
    .IF_ID_en    (if_id_en),
    .IF_ID_flush (if_id_flush),
    .ID_EX_en    (id_ex_en),
    .ID_EX_flush (id_ex_flush),
    .EX_MEM_en   (ex_mem_en),
    .MEM_WB_en   (mem_wb_en),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: waiting = previous cycle froze the pipe on memory,
  // run = length of the current freeze streak.
  bit m_wait;
  int m_run;
  int m_stall, m_flush;
  bit m_tout;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic check_counters(input string tag);
    check_val({tag, "_stall"}, 32'(stall_cnt), 32'(sat(m_stall)));
    check_val({tag, "_flush"}, 32'(flush_cnt), 32'(sat(m_flush)));
    check_val({tag, "_tout"},  32'(mem_timeout), 32'(m_tout));
  endtask

  // Asynchronous reset asserted between edges, held, then released into the INIT cycle.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    m_wait = 0; m_run = 0; m_stall = 0; m_flush = 0; m_tout = 0;
    check_val("rst_ctrl", 32'(ctrl_vec()), 32'(C_INIT));
    check_counters("rst");
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      check_val("rst_hold_ctrl", 32'(ctrl_vec()), 32'(C_INIT));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("init_ctrl", 32'(ctrl_vec()), 32'(C_INIT));
    check_counters("init");
  endtask

  // One clock cycle in RUN/MEM_WAIT territory: drive, check against the model, advance the model.
  task automatic cycle(input logic [4:0] a1, input logic [4:0] a2, input logic e1, input logic e2,
                       input logic [4:0] d, input logic w, input logic [1:0] m,
                       input logic r, input logic q, input logic y);
    logic       lu, freeze;
    logic [6:0] exp;
    @(negedge clk);
    rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; rw = w; m2r = m;
    redir = r; req = q; rdy = y;
    #1;
    lu     = w && (m == 2'b01) && (d != 5'd0) && ((e1 && a1 == d) || (e2 && a2 == d));
    freeze = m_wait ? !y : (q && !y);
    if (freeze)      exp = C_FREEZE;
    else if (r)      exp = C_REDIR;
    else if (lu)     exp = C_STALL;
    else             exp = C_NORMAL;
    check_val("ctrl", 32'(ctrl_vec()), 32'(exp));
    check_counters("cyc");
    if (!freeze) begin
      if (r)       m_flush++;
      else if (lu) m_stall++;
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == WAIT_MAX + 1) m_tout = 1;
    end
    m_wait = freeze;
  endtask

  task automatic idle();
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; rd = '0; rw = 0; m2r = '0;
    redir = 0; req = 0; rdy = 1;

    do_reset(3);
    idle();

    // Load-use: lw x5 in EX, add x6,x5,x7 in ID.
    cycle(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    idle();
    check_val("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    // Destination x0 never stalls.
    cycle(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    // Non-load producer does not stall.
    cycle(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    idle();
    check_val("x0_stall_cnt", 32'(stall_cnt), 32'd1);

    // Redirect together with load-use: flush wins.
    cycle(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    idle();
    check_val("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    check_val("redir_stall_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait for 4 cycles, then resume.
    for (int i = 0; i < 4; i++) cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    idle();
    check_val("short_wait_tout", 32'(mem_timeout), 32'd0);

    // Long wait triggers sticky timeout.
    for (int i = 0; i < 10; i++) cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    idle(); idle();
    check_val("long_wait_tout", 32'(mem_timeout), 32'd1);

    // Stall counter saturation.
    for (int i = 0; i < 20; i++) cycle(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    sample();
    check_val("sat_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));

    // Async reset in the middle of a memory wait.
    for (int i = 0; i < 3; i++) cycle(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    do_reset(2);
    check_val("post_rst_stall", 32'(stall_cnt), 32'd0);
    idle();

    // Randomized traffic with small register ranges to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1);
      cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 4) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
